// File: rtl/regfile_sb.sv
// Two-write-port register file with full write-to-read bypass and a load
// scoreboard that produces the decode stall and a sticky write-after-write hazard flag.
module regfile_sb #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int DISCARD_REG = 7
) (
  input  logic                         clk,
  input  logic                         CPU_RESET_n,
  input  logic [ADDR_W-1:0]            rd_addr_0,
  input  logic [ADDR_W-1:0]            rd_addr_1,
  input  logic                         rd_en_0,
  input  logic                         rd_en_1,
  input  logic [ADDR_W-1:0]            rd_addr_dbg,
  output logic [WIDTH-1:0]             rd_data_0,
  output logic [WIDTH-1:0]             rd_data_1,
  output logic [WIDTH-1:0]             rd_data_dbg,
  input  logic                         wa_en,
  input  logic [ADDR_W-1:0]            wa_addr,
  input  logic [WIDTH-1:0]             wa_data,
  input  logic                         wb_en,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [WIDTH-1:0]             wb_data,
  input  logic                         ld_issue,
  input  logic [ADDR_W-1:0]            ld_dest,
  output logic                         stall,
  output logic [DEPTH-1:0]             pending,
  output logic [$clog2(DEPTH+1)-1:0]   ld_outstanding,
  output logic                         err_waw
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [ADDR_W:0] DISC_A  = (ADDR_W+1)'(DISCARD_REG);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wa_eff, wb_eff, ld_eff;
  logic [DEPTH-1:0]  pending_nxt;
  logic              err_set;
  logic [ADDR_W-1:0] rd_addr_v [3];
  logic [WIDTH-1:0]  rd_data_v [3];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_A;
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return in_range(a) && ({1'b0, a} != DISC_A);
  endfunction

  // Write ports have no back-pressure: every effective write is accepted the cycle it is presented.
  assign wa_eff = wa_en && addr_ok(wa_addr);
  assign wb_eff = wb_en && addr_ok(wb_addr);
  assign ld_eff = ld_issue && addr_ok(ld_dest);

  assign rd_addr_v[0] = rd_addr_0;
  assign rd_addr_v[1] = rd_addr_1;
  assign rd_addr_v[2] = rd_addr_dbg;

  // Bypass priority: port B (load write-back) over port A over the array.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rd_data_v[i] = '0;
      if (in_range(rd_addr_v[i])) begin
        if (wb_eff && wb_addr == rd_addr_v[i])      rd_data_v[i] = wb_data;
        else if (wa_eff && wa_addr == rd_addr_v[i]) rd_data_v[i] = wa_data;
        else                                        rd_data_v[i] = mem[rd_addr_v[i]];
      end
    end
  end

  assign rd_data_0   = rd_data_v[0];
  assign rd_data_1   = rd_data_v[1];
  assign rd_data_dbg = rd_data_v[2];

  always_comb begin
    stall = 1'b0;
    if (rd_en_0 && in_range(rd_addr_0) && pending[rd_addr_0] &&
        !(wb_eff && wb_addr == rd_addr_0))
      stall = 1'b1;
    if (rd_en_1 && in_range(rd_addr_1) && pending[rd_addr_1] &&
        !(wb_eff && wb_addr == rd_addr_1))
      stall = 1'b1;
  end

  // A new load wins over the write-back of an older load to the same register.
  always_comb begin
    pending_nxt = pending;
    for (int r = 0; r < DEPTH; r++) begin
      if (ld_eff && ld_dest == ADDR_W'(r))      pending_nxt[r] = 1'b1;
      else if (wb_eff && wb_addr == ADDR_W'(r)) pending_nxt[r] = 1'b0;
    end
  end

  always_comb begin
    err_set = 1'b0;
    if (wa_eff && pending[wa_addr])                 err_set = 1'b1;
    if (wa_eff && wb_eff && wa_addr == wb_addr)     err_set = 1'b1;
    if (ld_eff && pending[ld_dest])                 err_set = 1'b1;
  end

  always_comb begin
    ld_outstanding = '0;
    for (int r = 0; r < DEPTH; r++)
      ld_outstanding = ld_outstanding + CNT_W'(pending[r]);
  end

  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      pending <= '0;
      err_waw <= 1'b0;
    end else begin
      if (wa_eff) mem[wa_addr] <= wa_data;
      if (wb_eff) mem[wb_addr] <= wb_data;
      pending <= pending_nxt;
      if (err_set) err_waw <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus a randomized run against a reference model,
// with read data flowing through an expected-value queue.
module tb_regfile_sb;
  localparam int W = 16;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk;
  logic         CPU_RESET_n;
  logic [A-1:0] rd_addr_0, rd_addr_1, rd_addr_dbg;
  logic         rd_en_0, rd_en_1;
  logic [W-1:0] rd_data_0, rd_data_1, rd_data_dbg;
  logic         wa_en, wb_en, ld_issue;
  logic [A-1:0] wa_addr, wb_addr, ld_dest;
  logic [W-1:0] wa_data, wb_data;
  logic         stall, err_waw;
  logic [D-1:0] pending;
  logic [3:0]   ld_outstanding;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int n_vec = 0;
  int n_err = 0;

  regfile_sb #(.WIDTH(W), .DEPTH(D), .ADDR_W(A), .DISCARD_REG(7)) dut (
    .clk(clk), .CPU_RESET_n(CPU_RESET_n),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_en_0(rd_en_0), .rd_en_1(rd_en_1),
    .rd_addr_dbg(rd_addr_dbg),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1), .rd_data_dbg(rd_data_dbg),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_issue(ld_issue), .ld_dest(ld_dest),
    .stall(stall), .pending(pending), .ld_outstanding(ld_outstanding),
    .err_waw(err_waw)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    rd_addr_0 = '0; rd_addr_1 = '0; rd_addr_dbg = '0;
    rd_en_0 = 1'b0; rd_en_1 = 1'b0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ld_issue = 1'b0; ld_dest = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    CPU_RESET_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    CPU_RESET_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < D; a++) begin
      @(negedge clk);
      rd_addr_0 = A'(a);
      exp_q.push_back('0);
      #1;
      exp_v = exp_q.pop_front();
      n_vec++;
      if (rd_data_0 !== exp_v) begin
        n_err++; $display("FAIL reset_read r%0d: got %h want %h", a, rd_data_0, exp_v);
      end
    end
    n_vec++;
    if (pending !== '0 || err_waw !== 1'b0 || stall !== 1'b0 || ld_outstanding !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: pend=%b err=%b stall=%b cnt=%0d want all 0",
               pending, err_waw, stall, ld_outstanding);
    end
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'h1234; rd_addr_0 = 3'd3;
    exp_q.push_back(16'h1234);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (rd_data_0 !== exp_v) begin
      n_err++; $display("FAIL bypass_a: got %h want %h", rd_data_0, exp_v);
    end
    @(negedge clk);
    wa_en = 1'b0;
    exp_q.push_back(16'h1234);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (rd_data_0 !== exp_v) begin
      n_err++; $display("FAIL array_a: got %h want %h", rd_data_0, exp_v);
    end
  endtask

  task automatic test_discard();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 3'd7; wa_data = 16'hBEEF; rd_addr_0 = 3'd7;
    exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (rd_data_0 !== exp_v) begin
      n_err++; $display("FAIL discard_bypass: got %h want %h", rd_data_0, exp_v);
    end
    @(negedge clk);
    wa_en = 1'b0; ld_issue = 1'b1; ld_dest = 3'd7;
    exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (rd_data_0 !== exp_v) begin
      n_err++; $display("FAIL discard_array: got %h want %h", rd_data_0, exp_v);
    end
    @(negedge clk);
    ld_issue = 1'b0;
    n_vec++;
    if (pending !== '0 || err_waw !== 1'b0) begin
      n_err++; $display("FAIL discard_load: pend=%b err=%b want 0/0", pending, err_waw);
    end
  endtask

  task automatic test_load_stall();
    @(negedge clk);
    ld_issue = 1'b1; ld_dest = 3'd2;
    @(negedge clk);
    ld_issue = 1'b0; rd_addr_0 = 3'd2; rd_en_0 = 1'b1;
    #1;
    n_vec++;
    if (stall !== 1'b1 || ld_outstanding !== 4'd1 || pending !== 8'b0000_0100) begin
      n_err++;
      $display("FAIL load_stall: stall=%b cnt=%0d pend=%b want 1/1/00000100",
               stall, ld_outstanding, pending);
    end
    @(negedge clk);
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL load_stall_hold: got %b want 1", stall);
    end
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h00AA;
    exp_q.push_back(16'h00AA);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (stall !== 1'b0 || rd_data_0 !== exp_v) begin
      n_err++; $display("FAIL wb_release: stall=%b data=%h want 0/%h", stall, rd_data_0, exp_v);
    end
    @(negedge clk);
    wb_en = 1'b0;
    exp_q.push_back(16'h00AA);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (pending !== '0 || stall !== 1'b0 || rd_data_0 !== exp_v || err_waw !== 1'b0) begin
      n_err++;
      $display("FAIL wb_after: pend=%b stall=%b data=%h err=%b want 0/0/%h/0",
               pending, stall, rd_data_0, err_waw, exp_v);
    end
    rd_en_0 = 1'b0;
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 3'd5; wa_data = 16'h1111;
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h2222;
    rd_addr_1 = 3'd5; rd_addr_dbg = 3'd5;
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h2222);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (rd_data_1 !== exp_v) begin
      n_err++; $display("FAIL ab_bypass_1: got %h want %h", rd_data_1, exp_v);
    end
    exp_v = exp_q.pop_front();
    n_vec++;
    if (rd_data_dbg !== exp_v || err_waw !== 1'b0) begin
      n_err++; $display("FAIL ab_bypass_dbg: data=%h err=%b want %h/0", rd_data_dbg, err_waw, exp_v);
    end
    @(negedge clk);
    wa_en = 1'b0; wb_en = 1'b0;
    exp_q.push_back(16'h2222);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (rd_data_1 !== exp_v || err_waw !== 1'b1) begin
      n_err++; $display("FAIL ab_array: data=%h err=%b want %h/1", rd_data_1, err_waw, exp_v);
    end
  endtask

  task automatic test_ld_wb_same();
    do_reset();
    @(negedge clk);
    ld_issue = 1'b1; ld_dest = 3'd4;
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h4444;
    @(negedge clk);
    ld_issue = 1'b0; wb_en = 1'b0; rd_addr_0 = 3'd4; rd_en_0 = 1'b1;
    #1;
    n_vec++;
    if (pending !== 8'b0001_0000 || err_waw !== 1'b0 || ld_outstanding !== 4'd1 || stall !== 1'b1) begin
      n_err++;
      $display("FAIL ld_wb_same: pend=%b err=%b cnt=%0d stall=%b want 00010000/0/1/1",
               pending, err_waw, ld_outstanding, stall);
    end
    rd_en_0 = 1'b0;
  endtask

  task automatic test_no_stall();
    @(negedge clk);
    ld_issue = 1'b1; ld_dest = 3'd1;
    @(negedge clk);
    ld_issue = 1'b0; rd_addr_1 = 3'd1; rd_en_1 = 1'b0; rd_addr_dbg = 3'd1;
    rd_addr_0 = 3'd4; rd_en_0 = 1'b0;
    exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (stall !== 1'b0 || rd_data_dbg !== exp_v || ld_outstanding !== 4'd2) begin
      n_err++;
      $display("FAIL no_stall: stall=%b dbg=%h cnt=%0d want 0/%h/2", stall, rd_data_dbg, ld_outstanding, exp_v);
    end
    rd_en_1 = 1'b1;
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL stall_en1: got %b want 1", stall);
    end
    @(negedge clk);
    rd_en_1 = 1'b0; ld_issue = 1'b1; ld_dest = 3'd1;
    @(negedge clk);
    ld_issue = 1'b0;
    #1;
    n_vec++;
    if (err_waw !== 1'b1) begin
      n_err++; $display("FAIL reissue_err: got %b want 1", err_waw);
    end
  endtask

  task automatic test_async_reset();
    rd_en_1 = 1'b1; rd_addr_1 = 3'd1;
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_stall: got %b want 1", stall);
    end
    CPU_RESET_n = 1'b0;
    #1;
    n_vec++;
    if (pending !== '0 || err_waw !== 1'b0 || stall !== 1'b0 || ld_outstanding !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset: pend=%b err=%b stall=%b cnt=%0d want all 0",
               pending, err_waw, stall, ld_outstanding);
    end
    @(negedge clk);
    CPU_RESET_n = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h5555;
    @(negedge clk);
    wb_en = 1'b0;
    exp_q.push_back(16'h5555);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (pending !== '0 || stall !== 1'b0 || rd_data_1 !== exp_v) begin
      n_err++;
      $display("FAIL late_wb: pend=%b stall=%b data=%h want 0/0/%h", pending, stall, rd_data_1, exp_v);
    end
    rd_en_1 = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] m_mem [D];
    logic [D-1:0] m_pend;
    logic         m_err, wa_e, wb_e, ld_e, exp_stall;
    logic [A-1:0] ra [3];
    logic [W-1:0] got [3];
    do_reset();
    for (int r = 0; r < D; r++) m_mem[r] = '0;
    m_pend = '0;
    m_err  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      wa_en = ($urandom_range(0, 2) != 0); wa_addr = A'($urandom_range(0, 7)); wa_data = W'($urandom);
      wb_en = ($urandom_range(0, 2) == 0); wb_addr = A'($urandom_range(0, 7)); wb_data = W'($urandom);
      ld_issue = ($urandom_range(0, 3) == 0); ld_dest = A'($urandom_range(0, 7));
      rd_addr_0 = A'($urandom_range(0, 7)); rd_addr_1 = A'($urandom_range(0, 7));
      rd_addr_dbg = A'($urandom_range(0, 7));
      rd_en_0 = ($urandom_range(0, 1) == 1); rd_en_1 = ($urandom_range(0, 1) == 1);
      wa_e = wa_en && (wa_addr != 3'd7);
      wb_e = wb_en && (wb_addr != 3'd7);
      ld_e = ld_issue && (ld_dest != 3'd7);
      ra[0] = rd_addr_0; ra[1] = rd_addr_1; ra[2] = rd_addr_dbg;
      for (int p = 0; p < 3; p++) begin
        if (wb_e && wb_addr == ra[p])      exp_q.push_back(wb_data);
        else if (wa_e && wa_addr == ra[p]) exp_q.push_back(wa_data);
        else                               exp_q.push_back(m_mem[ra[p]]);
      end
      exp_stall = (rd_en_0 && m_pend[rd_addr_0] && !(wb_e && wb_addr == rd_addr_0)) ||
                  (rd_en_1 && m_pend[rd_addr_1] && !(wb_e && wb_addr == rd_addr_1));
      #1;
      got[0] = rd_data_0; got[1] = rd_data_1; got[2] = rd_data_dbg;
      for (int p = 0; p < 3; p++) begin
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got[p] !== exp_v) begin
          n_err++; $display("FAIL rand_read c%0d p%0d: got %h want %h", c, p, got[p], exp_v);
        end
      end
      n_vec++;
      if (stall !== exp_stall || pending !== m_pend || err_waw !== m_err ||
          ld_outstanding !== 4'($countones(m_pend))) begin
        n_err++;
        $display("FAIL rand_state c%0d: stall=%b pend=%b err=%b cnt=%0d want %b/%b/%b/%0d", c,
                 stall, pending, err_waw, ld_outstanding, exp_stall, m_pend, m_err, $countones(m_pend));
      end
      // advance the model to the state after the coming edge
      if ((wa_e && m_pend[wa_addr]) || (wa_e && wb_e && wa_addr == wb_addr) ||
          (ld_e && m_pend[ld_dest]))
        m_err = 1'b1;
      if (wa_e) m_mem[wa_addr] = wa_data;
      if (wb_e) m_mem[wb_addr] = wb_data;
      if (wb_e) m_pend[wb_addr] = 1'b0;
      if (ld_e) m_pend[ld_dest] = 1'b1;
    end
    clear_inputs();
  endtask

  initial begin
    CPU_RESET_n = 1'b0;
    clear_inputs();
    test_reset();
    test_write_bypass();
    test_discard();
    test_load_stall();
    test_same_addr();
    test_ld_wb_same();
    test_no_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with two write ports, full combinational write-to-read bypass and a load scoreboard. It is the successor to the CPU's 8×16 register file. It sits between decode and the execute/memory write-back paths. Besides storing and forwarding values, it tracks registers whose load data is still outstanding and produces the decode stall itself, so decode no longer has to count cycles.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 8, number of architectural registers
- ADDR_W, 3, register address width; must satisfy 2^ADDR_W ≥ DEPTH
- DISCARD_REG, 7, address whose writes are dropped and whose load issues are ignored; set to DEPTH to disable the feature

Ports:
- clk  in  1  single clock; all state updates on rising edge
- CPU_RESET_n  in  1  asynchronous, active-low reset
- rd_addr_0, rd_addr_1  in  ADDR_W  decode read addresses
- rd_en_0, rd_en_1  in  1  the read is actually needed; gates stall generation only
- rd_addr_dbg  in  ADDR_W  debug read address; never stalls
- rd_data_0, rd_data_1, rd_data_dbg  out  WIDTH  read data, bypassed
- wa_en, wa_addr, wa_data  in  1/ADDR_W/WIDTH  write port A, from execute
- wb_en, wb_addr, wb_data  in  1/ADDR_W/WIDTH  write port B, memory load write-back
- ld_issue, ld_dest  in  1/ADDR_W  a load targeting ld_dest was issued this cycle
- stall  out  1  decode must hold its current instruction
- pending  out  DEPTH  per-register outstanding-load bits, registered
- ld_outstanding  out  clog2(DEPTH+1)  popcount of pending
- err_waw  out  1  sticky hazard flag, registered

## Operation
- Reset (asynchronous, while CPU_RESET_n = 0):
  - every register = 0, pending = 0, err_waw = 0
  - consequently stall = 0 and ld_outstanding = 0, given port enables are low
- Write qualification:
  - a port write is effective when its enable = 1, its address ≠ DISCARD_REG, and its address < DEPTH
  - effective writes update the array at the posedge
  - if A and B target the same address in the same cycle, B's data is stored
- Read path (combinational), in priority order:
  - effective B write to the address → wb_data
  - else effective A write to the address → wa_data
  - else array contents
  - addresses ≥ DEPTH read 0
  - the same rules apply to all three read ports
- Scoreboard, per register r, evaluated at the posedge:
  - set pending[r] on ld_issue with ld_dest = r (ignored if r = DISCARD_REG or r ≥ DEPTH)
  - else clear pending[r] on an effective B write to r
  - set has priority, so a new load and the write-back of an older load to the same r leave r pending
- Stall:
  - stall = (rd_en_0 ∧ pending[rd_addr_0] ∧ ¬Bhit_0) ∨ (rd_en_1 ∧ pending[rd_addr_1] ∧ ¬Bhit_1)
  - Bhit_n means an effective B write to rd_addr_n this cycle; the bypassed data is valid, so no stall
- err_waw is set, and stays set until reset, on:
  - an effective A write to a register whose pending bit is 1
  - A and B effective writes to the same address in the same cycle
  - ld_issue to a register that is already pending
  - in each case the write still proceeds as described above

## Timing
- Read latency 0: combinational from addresses and write ports.
- Write visible:
  - through bypass in the same cycle
  - from the array starting the cycle after the edge
- pending, ld_outstanding and err_waw change only at posedge or asynchronously at reset.
- stall is combinational from registered pending and the current-cycle inputs.
- Minimum load-use gap:
  - ld_issue at edge N makes pending visible in cycle N+1
  - a write-back in cycle M releases the stall in cycle M, via bypass
- Reset asserted mid-load:
  - pending is cleared immediately and stall drops
  - a later wb write still writes the array but does not set pending
- No back-pressure to the write ports; every effective write is accepted.

## Test plan
- Reset then read all 8 registers → all 0. Write A r3 = 0x1234 → rd_data_0 = 0x1234 the same cycle (bypass), and again the next cycle from the array.
- Write A to r7 = 0xBEEF, then read r7 → 0; ld_issue with ld_dest = 7 → pending stays 0.
- ld_issue r2 at edge 1; cycle 2 read r2 with rd_en_0 = 1 → stall = 1, ld_outstanding = 1. Cycle 4 wb r2 = 0x00AA → stall = 0 and rd_data_0 = 0x00AA in cycle 4; pending[2] = 0 after edge 4.
- Same cycle: wa r5 = 0x1111 and wb r5 = 0x2222 → read r5 = 0x2222, err_waw = 1 after the edge.
- ld_issue r4 and wb r4 in the same cycle → pending[4] stays 1 and err_waw = 0, since r4 was not already pending.
- Pending r1 with rd_en_1 = 0, or read via the debug port only → stall = 0. Pull CPU_RESET_n low mid-cycle → pending = 0 and err_waw = 0 without a clock edge.
